// File: rtl/rom_stream_reader.sv
// Sequencer for a synchronous lookup ROM: issues reads, absorbs the one-cycle
// read latency and streams the words out through a 4-entry FIFO with valid/ready/last.
module rom_stream_reader #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q;
    logic                  busy_q, done_q, err_q;
    logic                  rom_rd_en_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic                  issue_last_q;
    logic                  ret_valid_q, ret_last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  remaining_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [4];
    logic                  fifo_last_q [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            occ_q;

    logic                  push, pop, start_ok;
    logic [2:0]            occ_d;
    logic                  issue_d, issue_last_d;
    logic [ADDR_WIDTH-1:0] issue_addr_d, addr_d;
    logic [CNT_WIDTH-1:0]  issue_rem_d;

    // Reads are only issued if the FIFO can still hold them once everything
    // already in flight has landed, so the FIFO never overflows.
    always_comb begin
        push         = ret_valid_q;
        pop          = (occ_q != 3'd0) && out_ready;
        occ_d        = occ_q + {2'b00, push} - {2'b00, pop};
        start_ok     = (state_q == IDLE) && start && (start_addr <= LAST_ADDR) && (count != '0);
        issue_d      = start_ok || ((state_q == READ) && ((occ_d + {2'b00, rom_rd_en_q}) < 3'd4));
        issue_addr_d = start_ok ? start_addr : addr_q;
        issue_rem_d  = start_ok ? count : remaining_q;
        issue_last_d = (issue_rem_d == CNT_WIDTH'(1));
        addr_d       = (issue_addr_d == LAST_ADDR) ? '0 : issue_addr_d + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rom_rd_en_q  <= 1'b0;
            rom_addr_q   <= '0;
            issue_last_q <= 1'b0;
            ret_valid_q  <= 1'b0;
            ret_last_q   <= 1'b0;
            addr_q       <= '0;
            remaining_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
        end else begin
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rom_rd_en_q  <= issue_d;
            issue_last_q <= issue_d && issue_last_d;
            ret_valid_q  <= rom_rd_en_q;
            ret_last_q   <= issue_last_q;
            occ_q        <= occ_d;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            if (issue_d) begin
                rom_addr_q  <= issue_addr_d;
                addr_q      <= addr_d;
                remaining_q <= issue_rem_d - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (start_addr > LAST_ADDR) begin
                            err_q <= 1'b1;
                        end else if (count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= issue_last_d ? DRAIN : READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue_d && issue_last_d) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!rom_rd_en_q && !ret_valid_q && (occ_d == 3'd0)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; empty entries are never visible because
    // out_data is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rom_data;
            fifo_last_q[wr_ptr_q] <= ret_last_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rom_rd_en = rom_rd_en_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = (occ_q != 3'd0);
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench: a registered ROM model, directed scenarios and random
// transfers scored against a list-of-expected-beats reference model.
module tb_rom_stream_reader;

    localparam int DEPTH = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] start_addr = '0;
    logic [7:0] count = '0;
    logic       busy, done, err, rom_rd_en;
    logic [2:0] rom_addr;
    logic [8:0] rom_data = '0;
    logic [8:0] out_data;
    logic       out_valid, out_last;
    logic       out_ready = 1'b1;

    logic [8:0] rom [DEPTH] = '{9'h1FB, 9'h101, 9'h000, 9'h0FF, 9'h1FF};

    rom_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
        .busy(busy), .done(done), .err(err), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_rd_en && int'(rom_addr) < DEPTH) rom_data <= rom[rom_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state, sampled on the falling edge.
    int cyc = 0;
    int rd_cnt, done_cnt, err_cnt, valid_cnt, stab_viol, oob_cnt;
    int first_rd, first_valid, first_beat, last_beat_cyc, done_cyc;
    bit busy_seen, prev_stall;
    logic [8:0] prev_data;
    logic       prev_last;
    logic [9:0] beat_q [$];
    logic [9:0] exp_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (rom_rd_en) begin
                rd_cnt++;
                if (int'(rom_addr) >= DEPTH) oob_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            if (busy) busy_seen = 1'b1;
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stab_viol++;
            if (out_valid && out_ready) begin
                beat_q.push_back({out_last, out_data});
                last_beat_cyc = cyc;
                if (first_beat < 0) first_beat = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic clear_stats();
        rd_cnt = 0; done_cnt = 0; err_cnt = 0; valid_cnt = 0;
        first_rd = -1; first_valid = -1; first_beat = -1; last_beat_cyc = -1; done_cyc = -1;
        busy_seen = 1'b0;
        beat_q.delete();
    endtask

    // Reference model: the words a transfer must deliver, in order.
    task automatic build_exp(input int a, input int c);
        exp_q.delete();
        if (a < DEPTH) begin
            for (int i = 0; i < c; i++)
                exp_q.push_back({(i == c - 1), rom[(a + i) % DEPTH]});
        end
    endtask

    task automatic compare_beats(input string tag);
        check({tag, "_nbeats"}, beat_q.size(), exp_q.size());
        for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), beat_q[i], exp_q[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rd_en"}, rom_rd_en, 0);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_data"}, out_data, 0);
    endtask

    int start_cyc;

    // Runs one transfer; stall>0 holds out_ready low for that many cycles
    // and also fires an illegal start while the block is busy.
    task automatic run_xfer(input int a, input int c, input bit rmode, input int stall);
        int k;
        int budget;
        budget = c * 8 + 30;
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 3'(a); count = 8'(c); start_cyc = cyc;
        out_ready = (stall > 0) ? 1'b0 : (rmode ? ($urandom_range(0, 3) != 0) : 1'b1);
        k = 0;
        while (done_cnt == 0 && err_cnt == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
            start = (stall > 0 && k == 2);
            if (start) start_addr = 3'd6;
            if (k <= stall)  out_ready = 1'b0;
            else if (rmode)  out_ready = ($urandom_range(0, 3) != 0);
            else             out_ready = 1'b1;
            if (stall > 0 && k == stall) begin
                check("stall_rd_issues", rd_cnt, 4);
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, 9'h1FB);
            end
        end
        if (done_cnt == 0 && err_cnt == 0) check("timeout", 0, 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        clear_stats();
        oob_cnt = 0; stab_viol = 0; prev_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Full table, no backpressure: latency, order, last, done timing.
        run_xfer(0, 5, 1'b0, 0);
        build_exp(0, 5);
        compare_beats("seq0");
        check("seq0_first_rd", first_rd - start_cyc, 1);
        check("seq0_first_valid", first_valid - start_cyc, 3);
        check("seq0_back_to_back", last_beat_cyc - first_beat, 4);
        check("seq0_done_after_last", done_cyc - last_beat_cyc, 1);
        check("seq0_done_cnt", done_cnt, 1);
        check("seq0_busy_end", busy, 0);

        // Address wrap 4 -> 0.
        run_xfer(3, 4, 1'b0, 0);
        build_exp(3, 4);
        compare_beats("wrap");
        check("wrap_done_cnt", done_cnt, 1);

        // Long stall, with a start fired while busy.
        run_xfer(0, 5, 1'b0, 10);
        build_exp(0, 5);
        compare_beats("stall");
        check("stall_busy_start_no_err", err_cnt, 0);
        check("stall_done_cnt", done_cnt, 1);

        // Zero-length transfer.
        run_xfer(2, 0, 1'b0, 0);
        check("zero_rd", rd_cnt, 0);
        check("zero_valid", valid_cnt, 0);
        check("zero_done_cnt", done_cnt, 1);

        // Out-of-range start address.
        run_xfer(6, 3, 1'b0, 0);
        check("bad_err_cnt", err_cnt, 1);
        check("bad_busy", busy_seen, 0);
        check("bad_rd", rd_cnt, 0);
        check("bad_done", done_cnt, 0);

        // Reset in the middle of a transfer.
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 3'd0; count = 8'd5; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20 && beat_q.size() < 2; k++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_beats_before", beat_q.size(), 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_no_more_beats", beat_q.size(), 2);
        run_xfer(1, 2, 1'b0, 0);
        build_exp(1, 2);
        compare_beats("after_rst");

        // Random transfers with random backpressure.
        for (int t = 0; t < 25; t++) begin
            int a;
            int c;
            a = $urandom_range(0, 7);
            c = $urandom_range(0, 12);
            run_xfer(a, c, 1'b1, 0);
            build_exp(a, c);
            compare_beats($sformatf("rnd%0d", t));
            check($sformatf("rnd%0d_err", t), err_cnt, (a >= DEPTH) ? 1 : 0);
            check($sformatf("rnd%0d_done", t), done_cnt, (a >= DEPTH) ? 0 : 1);
            check($sformatf("rnd%0d_rd", t), rd_cnt, (a >= DEPTH) ? 0 : c);
        end

        check("stability_violations", stab_viol, 0);
        check("out_of_range_reads", oob_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Upstream sequencer for the synchronous read-only lookup tables (for example, the 9-bit x 5-entry ROM).
- Drives the ROM's rd_en/addr pins, absorbs its 1-cycle registered read latency, and presents the fetched words as a valid/ready stream with a last marker.
- Sits between a control unit, which issues start/start_addr/count, and datapath consumers that may apply backpressure.

Parameters:
- DATA_WIDTH, 9, ROM word width.
- ADDR_WIDTH, 3, ROM address width.
- DEPTH, 5, number of populated ROM entries; valid addresses are 0..DEPTH-1.
- CNT_WIDTH, 8, width of the transfer word count.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- start_addr  input  ADDR_WIDTH  first ROM address of the transfer.
- count  input  CNT_WIDTH  number of words to stream; 0 is legal.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the transfer completes.
- err  output  1  one-cycle pulse when a start is rejected.
- rom_rd_en  output  1  ROM read enable.
- rom_addr  output  ADDR_WIDTH  ROM address.
- rom_data  input  DATA_WIDTH  ROM registered output, valid 1 cycle after rom_rd_en.
- out_data  output  DATA_WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from the consumer.
- out_last  output  1  high on the final beat of a transfer.

Behaviour:
- **Reset values:** the following are 0 on reset.
  - Outputs: busy, done, err, rom_rd_en, rom_addr, out_valid, out_last, out_data.
  - Internal: state=IDLE, FIFO flushed, in-flight tracker cleared.
- **Reset mid-transfer:** aborts the transfer. done is not pulsed. ROM data still returning after the reset is discarded.
- **States:** IDLE, READ, DRAIN, DONE.
- **IDLE:**
  - start with start_addr>=DEPTH: pulse err next cycle and stay in IDLE.
  - start with count==0: go to DONE (done pulse, no beats).
  - Otherwise: latch addr=start_addr and remaining=count, then go to READ.
- **READ:**
  - Issue rom_rd_en=1 with rom_addr=addr when occ+inflight<4. occ is the number of entries in the internal 4-entry output FIFO; inflight is the number of issued reads not yet written to the FIFO (0..2).
  - On each issue: addr increments and wraps from DEPTH-1 to 0; remaining decrements.
  - After the issue that makes remaining 0, go to DRAIN.
- **Data capture:**
  - A read issued in cycle N presents rom_data in cycle N+1.
  - That word is written to the FIFO at the end of N+1 and is visible on out_data/out_valid in N+2.
  - The captured word is tagged last if it was the final issue.
- **DRAIN:** when inflight==0 and the FIFO is empty after the final beat handshakes, go to DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- **Output stream:**
  - out_valid = FIFO not empty; out_data/out_last come from the FIFO head.
  - A beat transfers when out_valid && out_ready.
  - While out_valid is high and out_ready is low, out_data/out_last must hold stable.
- **Simultaneous events:** a FIFO write and read in the same cycle keep occ unchanged.
- **Throughput:** with out_ready held high, one beat per cycle sustained.
- **Latency:**
  - First rom_rd_en: cycle S+1, where S is the start cycle.
  - First out_valid: cycle S+3.
- **Start while busy:** ignored (no err).
- **Wrap and counts above DEPTH:** count>DEPTH wraps the address repeatedly.
- **Out-of-range reads:** the block never presents rom_addr>=DEPTH with rom_rd_en=1.

Test Plan:
All scenarios use ROM contents {0x1FB, 0x101, 0x000, 0x0FF, 0x1FF}.
- start, start_addr=0, count=5, out_ready=1.
  - Beats 0x1FB, 0x101, 0x000, 0x0FF, 0x1FF on consecutive cycles starting at S+3.
  - out_last on 0x1FF; done one cycle after the last beat.
- start_addr=3, count=4.
  - Beats 0x0FF, 0x1FF, 0x1FB, 0x101 (address wraps 4→0); last on 0x101.
- count=5, out_ready=0 for 10 cycles, then 1.
  - At most 4 rom_rd_en issues during the stall; out_data holds 0x1FB stable.
  - Full ordered sequence after release; no drop or duplicate.
- count=0.
  - No rom_rd_en, no out_valid; done pulses once.
- start_addr=6.
  - err pulses once, busy stays 0, no rom_rd_en.
- rst asserted mid-transfer (after 2 beats of count=5), then a new start with addr=1, count=2.
  - After rst: all outputs 0, no done pulse.
  - New transfer yields exactly 0x101, 0x000.
